sonic_rx_st_overflow_buffer: RTL and testbench

- Sits directly downstream of the 10G MAC RX Avalon-ST timing adapter, whose output cannot backpressure its source.
- Absorbs out_ready backpressure from the RX consumer in a small packet-aware FIFO.
- On overflow it never emits a corrupted or unterminated frame: a frame is either dropped whole or truncated with EOP and error set.
- Exports a drop counter and an overflow pulse for the status block.

---
 rtl/sonic_rx_st_pkg.sv | 23 ++
 rtl/sonic_rx_st_sync_fifo.sv | 76 +++++++
 rtl/sonic_rx_st_overflow_buffer.sv | 140 ++++++++++++++
 tb/tb_sonic_rx_st_overflow_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_rx_st_pkg.sv
// sonic_rx_st_pkg
// Shared definitions for the 10G MAC RX overflow buffer.
// - Bit offsets of the 72-bit Avalon-ST payload word:
//     [63:0] data, [64] sop, [65] eop, [68:66] empty, [71:69] error.
// - error[ERR_TRUNC] marks a frame that this block truncated on overflow.
// - State encoding for the admission FSM.
package sonic_rx_st_pkg;

  localparam int SOP_BIT   = 64;
  localparam int EOP_BIT   = 65;
  localparam int EMPTY_LSB = 66;
  localparam int ERR_LSB   = 69;
  localparam int ERR_TRUNC = 0;

  // IDLE: between frames, PASS: inside an accepted frame,
  // DROP: discarding the remainder of a frame.
  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP
  } rx_state_e;

endpackage

// File: rtl/sonic_rx_st_sync_fifo.sv
// sonic_rx_st_sync_fifo
// Generic single-clock first-word-fall-through FIFO.
// A word written at one clock edge is visible on rd_data, with rd_valid
// high, right after that edge. rd_data holds steady until it is read.
// Ports:
//   clk      - clock
//   reset_n  - synchronous active-low reset; empties the FIFO
//   wr_en    - write wr_data this cycle (the caller must never write when full)
//   wr_data  - word to write
//   rd_en    - consumer takes rd_data this cycle (ignored when empty)
//   rd_data  - head-of-queue word
//   rd_valid - rd_data holds a valid word
//   count    - current occupancy, 0 .. 2**DEPTH_LOG2
module sonic_rx_st_sync_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  rd_fire;

  assign rd_valid = (count != '0);
  assign rd_fire  = rd_en && rd_valid;
  assign rd_data  = mem[rd_ptr];

  // Storage needs no reset: entries are only observed once written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks occupancy and is left
  // unchanged when a write and a read land on the same edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      end
      case ({wr_en, rd_fire})
        2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Writing into a full FIFO would overwrite the head word.
  always_ff @(posedge clk) begin
    if (reset_n && wr_en) begin
      assert (count != FULL);
    end
  end

endmodule

// File: rtl/sonic_rx_st_overflow_buffer.sv
// sonic_rx_st_overflow_buffer
// Packet-aware overflow buffer behind the 10G MAC RX timing adapter.
// The upstream cannot be backpressured, so every valid input word is either
// stored or dropped in the cycle it arrives. Frames that do not fit are
// dropped whole (no room at sop) or truncated (closed with eop and
// error[ERR_TRUNC]); the downstream never sees an unterminated frame.
// Ports:
//   clk            - clock
//   reset_n        - synchronous active-low reset
//   in_data        - payload word from the timing adapter
//   in_valid       - in_data is valid
//   out_data       - payload word to the RX consumer
//   out_valid      - out_data is valid
//   out_ready      - consumer accepts out_data
//   overflow_pulse - one-cycle pulse per drop/truncate/orphan event
//   drop_count     - saturating count of those events
//   fill_level     - current FIFO occupancy
module sonic_rx_st_overflow_buffer
  import sonic_rx_st_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 72,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow_pulse,
  output logic [CNT_W-1:0]      drop_count,
  output logic [DEPTH_LOG2:0]   fill_level
);

  // Normal writes need count < DEPTH-1; the last slot is kept for a
  // truncation word so an accepted frame can always be closed.
  localparam logic [DEPTH_LOG2:0] ROOM_LIMIT =
    (DEPTH_LOG2 + 1)'((1 << DEPTH_LOG2) - 1);

  rx_state_e             state;
  rx_state_e             state_next;
  logic [DEPTH_LOG2:0]   count;
  logic                  has_room;
  logic                  in_sop;
  logic                  in_eop;
  logic                  wr_en;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W-1:0]     trunc_word;
  logic                  drop_event;

  sonic_rx_st_sync_fifo #(
    .WIDTH      (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (out_ready),
    .rd_data  (out_data),
    .rd_valid (out_valid),
    .count    (count)
  );

  assign fill_level = count;
  // Admission uses the registered count; a same-edge read is not credited.
  assign has_room   = (count < ROOM_LIMIT);
  assign in_sop     = in_data[SOP_BIT];
  assign in_eop     = in_data[EOP_BIT];

  // Closing word for a truncated frame. Clearing sop only matters on a
  // restart (sop inside a frame); otherwise sop is already 0.
  always_comb begin
    trunc_word                     = in_data;
    trunc_word[EOP_BIT]            = 1'b1;
    trunc_word[ERR_LSB+ERR_TRUNC]  = 1'b1;
    trunc_word[SOP_BIT]            = 1'b0;
  end

  // Admission decision for the current input word and next FSM state.
  always_comb begin
    state_next = state;
    wr_en      = 1'b0;
    wr_data    = in_data;
    drop_event = 1'b0;
    if (in_valid) begin
      case (state)
        IDLE: begin
          if (!in_sop) begin
            drop_event = 1'b1;
          end else if (has_room) begin
            wr_en = 1'b1;
            if (!in_eop) state_next = PASS;
          end else begin
            drop_event = 1'b1;
            if (!in_eop) state_next = DROP;
          end
        end
        PASS: begin
          if (in_sop) begin
            wr_en      = 1'b1;
            wr_data    = trunc_word;
            drop_event = 1'b1;
            state_next = IDLE;
          end else if (has_room) begin
            wr_en = 1'b1;
            if (in_eop) state_next = IDLE;
          end else begin
            wr_en      = 1'b1;
            wr_data    = trunc_word;
            drop_event = 1'b1;
            state_next = in_eop ? IDLE : DROP;
          end
        end
        DROP: begin
          if (in_eop) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State register, registered event pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      overflow_pulse <= 1'b0;
      drop_count     <= '0;
    end else begin
      state          <= state_next;
      overflow_pulse <= drop_event;
      if (drop_event && (drop_count != '1)) begin
        drop_count <= drop_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sonic_rx_st_overflow_buffer.sv
// tb_sonic_rx_st_overflow_buffer
// Directed scenarios followed by a random phase, all compared each cycle
// against a queue-based reference model of the overflow buffer.
module tb_sonic_rx_st_overflow_buffer;
  import sonic_rx_st_pkg::*;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int DATA_W     = 72;
  localparam int CNT_W      = 5;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [DATA_W-1:0]   in_data;
  logic                in_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_valid;
  logic                out_ready;
  logic                overflow_pulse;
  logic [CNT_W-1:0]    drop_count;
  logic [DEPTH_LOG2:0] fill_level;

  int test_count = 0;
  int fail_count = 0;

  // Reference model: stored words, frame mode, event counter and pulse.
  // mode 0 = between frames, 1 = accepting a frame, 2 = discarding a frame.
  logic [DATA_W-1:0] mq [$];
  int                m_mode  = 0;
  int                m_drops = 0;
  bit                m_pulse = 1'b0;

  always #5 clk = ~clk;

  sonic_rx_st_overflow_buffer #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .DATA_W     (DATA_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .overflow_pulse (overflow_pulse),
    .drop_count     (drop_count),
    .fill_level     (fill_level)
  );

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DATA_W-1:0] mk(input bit sop, input bit eop);
    logic [DATA_W-1:0] w;
    w[63:0]         = {$urandom, $urandom};
    w[SOP_BIT]      = sop;
    w[EOP_BIT]      = eop;
    w[68:66]        = 3'($urandom_range(0, 7));
    w[71:69]        = {2'($urandom_range(0, 3)), 1'b0};
    return w;
  endfunction

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    test_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the rules of the buffer:
  // read the head if present and ready, then admit/drop the input word
  // judged on the occupancy before the edge.
  task automatic model_edge(input bit rst_n, input bit v,
                            input logic [DATA_W-1:0] d, input bit rdy);
    int                pre;
    bit                pulse;
    bit                sop;
    bit                eop;
    logic [DATA_W-1:0] t;
    if (!rst_n) begin
      mq.delete();
      m_mode  = 0;
      m_drops = 0;
      m_pulse = 1'b0;
      return;
    end
    pre   = mq.size();
    pulse = 1'b0;
    if (rdy && pre > 0) void'(mq.pop_front());
    if (v) begin
      sop = d[SOP_BIT];
      eop = d[EOP_BIT];
      t = d;
      t[EOP_BIT] = 1'b1;
      t[ERR_LSB+ERR_TRUNC] = 1'b1;
      t[SOP_BIT] = 1'b0;
      if (m_mode == 0) begin
        if (!sop) pulse = 1'b1;
        else if (pre < DEPTH - 1) begin
          mq.push_back(d);
          m_mode = eop ? 0 : 1;
        end else begin
          pulse  = 1'b1;
          m_mode = eop ? 0 : 2;
        end
      end else if (m_mode == 1) begin
        if (sop) begin
          mq.push_back(t);
          pulse  = 1'b1;
          m_mode = 0;
        end else if (pre < DEPTH - 1) begin
          mq.push_back(d);
          if (eop) m_mode = 0;
        end else begin
          mq.push_back(t);
          pulse  = 1'b1;
          m_mode = eop ? 0 : 2;
        end
      end else begin
        if (eop) m_mode = 0;
      end
    end
    m_pulse = pulse;
    if (pulse && m_drops < CNT_MAX) m_drops++;
  endtask

  task automatic checkOutput();
    check("out_valid", DATA_W'(out_valid), DATA_W'(mq.size() != 0));
    if (mq.size() != 0) check("out_data", out_data, mq[0]);
    check("fill_level", DATA_W'(fill_level), DATA_W'(mq.size()));
    check("drop_count", DATA_W'(drop_count), DATA_W'(m_drops));
    check("overflow_pulse", DATA_W'(overflow_pulse), DATA_W'(m_pulse));
  endtask

  task automatic applyStimulus(input bit rst_n, input bit v,
                               input logic [DATA_W-1:0] d, input bit rdy);
    reset_n   = rst_n;
    in_valid  = v;
    in_data   = d;
    out_ready = rdy;
    @(posedge clk);
    model_edge(rst_n, v, d, rdy);
    #1;
    checkOutput();
  endtask

  task automatic send_frame(input int len, input bit rdy);
    for (int i = 0; i < len; i++) applyStimulus(1'b1, 1'b1, mk(i == 0, i == len - 1), rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, '0, rdy);
  endtask

  initial begin
    bit                gen_in;
    int                rem;
    bit                v;
    bit                rdy;
    bit                sop;
    bit                eop;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b1, mk(1'b1, 1'b0), 1'b1);
    check("reset_fill", DATA_W'(fill_level), DATA_W'(0));
    check("reset_valid", DATA_W'(out_valid), DATA_W'(0));

    // Streaming pass-through
    send_frame(4, 1'b1);
    send_frame(1, 1'b1);
    send_frame(9, 1'b1);
    idle(2, 1'b1);
    check("stream_drops", DATA_W'(drop_count), DATA_W'(0));

    // Mid-frame truncation with consumer stalled
    send_frame(20, 1'b0);
    check("trunc_fill", DATA_W'(fill_level), DATA_W'(16));
    check("trunc_drops", DATA_W'(drop_count), DATA_W'(1));
    idle(17, 1'b1);
    check("trunc_drain", DATA_W'(fill_level), DATA_W'(0));

    // Drop at sop with 15 words held
    send_frame(15, 1'b0);
    send_frame(5, 1'b0);
    check("sopdrop_fill", DATA_W'(fill_level), DATA_W'(15));
    check("sopdrop_drops", DATA_W'(drop_count), DATA_W'(2));
    idle(16, 1'b1);
    send_frame(3, 1'b1);
    idle(2, 1'b1);

    // Orphan, then a frame restarted on its third word
    applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b0), 1'b1);
    applyStimulus(1'b1, 1'b1, mk(1'b1, 1'b0), 1'b1);
    applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b0), 1'b1);
    applyStimulus(1'b1, 1'b1, mk(1'b1, 1'b0), 1'b1);
    check("restart_drops", DATA_W'(drop_count), DATA_W'(4));
    send_frame(2, 1'b1);
    idle(2, 1'b1);

    // Simultaneous read/write while holding occupancy at 14
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, mk(i == 0, 1'b0), 1'b0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b0), 1'b1);
      check("steady_fill", DATA_W'(fill_level), DATA_W'(14));
    end
    applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b1), 1'b1);
    check("steady_drops", DATA_W'(drop_count), DATA_W'(4));
    idle(16, 1'b1);

    // Reset in the middle of a stored frame
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, mk(i == 0, 1'b0), 1'b0);
    applyStimulus(1'b0, 1'b1, mk(1'b0, 1'b0), 1'b0);
    check("midreset_valid", DATA_W'(out_valid), DATA_W'(0));
    check("midreset_fill", DATA_W'(fill_level), DATA_W'(0));
    check("midreset_drops", DATA_W'(drop_count), DATA_W'(0));
    applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b0), 1'b1);
    applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b0), 1'b1);
    applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b1), 1'b1);
    check("orphan_drops", DATA_W'(drop_count), DATA_W'(3));

    // Random traffic: frames, gaps, orphans, restarts and stalls
    gen_in = 1'b0;
    rem    = 0;
    for (int i = 0; i < 800; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = (i < 400) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
      sop = 1'b0;
      eop = 1'b0;
      if (v) begin
        if (!gen_in) begin
          if ($urandom_range(0, 9) == 0) begin
            eop = ($urandom_range(0, 1) == 1);
          end else begin
            sop    = 1'b1;
            rem    = $urandom_range(1, 12) - 1;
            eop    = (rem == 0);
            gen_in = !eop;
          end
        end else begin
          sop = ($urandom_range(0, 19) == 0);
          rem = rem - 1;
          eop = (rem <= 0);
          if (eop) gen_in = 1'b0;
        end
      end
      applyStimulus(1'b1, v, v ? mk(sop, eop) : '0, rdy);
    end

    // Drain, then saturate the drop counter with orphans
    applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b1), 1'b1);
    idle(20, 1'b1);
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b1, mk(1'b0, 1'b0), 1'b1);
    check("saturated_drops", DATA_W'(drop_count), DATA_W'(CNT_MAX));

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
